// File: rtl/uart_tx_sched.sv
// uart_tx_sched: drains the TX FIFO into UART_TX one byte per frame, with busy
// handshake, inter-frame gap, frame counting and acknowledge timeout detection.
module uart_tx_sched #(
    parameter int DATA_WIDTH  = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  CLR_ERR,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_INC,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT,
    output logic                  TIMEOUT_ERR,
    output logic                  SCHED_BUSY
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int GL = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t                state, state_nx, after_frame;
    logic [TW-1:0]         tcnt, tcnt_nx;
    logic [GW-1:0]         gcnt, gcnt_nx;
    logic [DATA_WIDTH-1:0] data_nx;
    logic [CNT_WIDTH-1:0]  cnt_nx;
    logic                  start, timeout, gap_done, err_nx;

    assign start       = EN & ~FIFO_EMPTY & ~TX_BUSY;
    assign timeout     = ~TX_BUSY & (tcnt == TW'(ACK_TIMEOUT - 1));
    assign gap_done    = gcnt == GW'(GL);
    assign after_frame = GAP_CYCLES == 0 ? IDLE : GAP;
    assign SCHED_BUSY  = state != IDLE;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = start ? SEND : IDLE;
            SEND:      state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = TX_BUSY ? WAIT_DONE : timeout ? after_frame : WAIT_BUSY;
            WAIT_DONE: state_nx = TX_BUSY ? WAIT_DONE : after_frame;
            GAP:       state_nx = gap_done ? IDLE : GAP;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        data_nx = (state == IDLE && start) ? FIFO_RD_DATA : TX_P_DATA;
        tcnt_nx = state == WAIT_BUSY ? tcnt + 1'b1 : '0;
        gcnt_nx = state == GAP ? gcnt + 1'b1 : '0;
        cnt_nx  = (state == WAIT_DONE && !TX_BUSY) ? FRAME_CNT + 1'b1 : FRAME_CNT;
        // a timeout raised in the same cycle as CLR_ERR must survive
        err_nx  = (state == WAIT_BUSY && timeout) | (TIMEOUT_ERR & ~CLR_ERR);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_P_DATA     <= '0;
            FIFO_RD_INC   <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            FRAME_CNT     <= '0;
            TIMEOUT_ERR   <= 1'b0;
            tcnt          <= '0;
            gcnt          <= '0;
        end else begin
            TX_P_DATA     <= data_nx;
            FIFO_RD_INC   <= state == IDLE && start;
            TX_DATA_VALID <= state == IDLE && start;
            FRAME_CNT     <= cnt_nx;
            TIMEOUT_ERR   <= err_nx;
            tcnt          <= tcnt_nx;
            gcnt          <= gcnt_nx;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized bench with a FIFO/UART behavioural model and
// byte-order, handshake, gap, timeout and frame-count checks.
module tb_uart_tx_sched;
    localparam int CW = 4;

    logic          CLK = 1'b0, RST = 1'b0, EN = 1'b0, CLR_ERR = 1'b0;
    logic          FIFO_EMPTY, FIFO_RD_INC, TX_BUSY, TX_DATA_VALID, TIMEOUT_ERR, SCHED_BUSY;
    logic [7:0]    FIFO_RD_DATA, TX_P_DATA;
    logic [CW-1:0] FRAME_CNT;

    logic [7:0] mem [0:255];
    int wp = 0, rp = 0, cyc = 0, n_chk = 0, n_pass = 0, n_pop = 0;
    int exp_frames = 0, last_fall = -1, bwait = 0, bhold = 0, blen_fix = 0, p0;
    logic mbusy = 1'b0, ext_busy = 1'b0, ack_en = 1'b1;

    assign FIFO_EMPTY   = wp == rp;
    assign FIFO_RD_DATA = mem[rp[7:0]];
    assign TX_BUSY      = mbusy | ext_busy;

    uart_tx_sched #(.DATA_WIDTH(8), .GAP_CYCLES(2), .ACK_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR_ERR(CLR_ERR),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_RD_INC(FIFO_RD_INC),
        .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
        .FRAME_CNT(FRAME_CNT), .TIMEOUT_ERR(TIMEOUT_ERR), .SCHED_BUSY(SCHED_BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[7:0]] = b;
        wp++;
    endtask

    task automatic wait_valid(input int lim);
        for (int n = 0; n < lim && !TX_DATA_VALID; n++) @(negedge CLK);
        check("valid_seen", 32'(TX_DATA_VALID), 1);
    endtask

    task automatic wait_busy(input int lim);
        for (int n = 0; n < lim && !TX_BUSY; n++) @(negedge CLK);
        check("busy_seen", 32'(TX_BUSY), 1);
    endtask

    function automatic logic quiet();
        return !SCHED_BUSY && !TX_BUSY && (wp == rp || !EN);
    endfunction

    task automatic wait_quiet(input int lim);
        @(negedge CLK);
        for (int n = 0; n < lim && !quiet(); n++) @(negedge CLK);
        check("quiet", 32'(quiet()), 1);
    endtask

    // FIFO read side, UART busy model and per-frame checks
    always @(negedge CLK) begin
        if (TX_DATA_VALID) begin
            check("rd_inc_with_valid", 32'(FIFO_RD_INC), 1);
            check("fifo_nonempty", 32'(wp != rp), 1);
            if (wp != rp) check("tx_byte", 32'(TX_P_DATA), 32'(mem[rp[7:0]]));
            if (last_fall >= 0) check("gap", 32'(cyc - last_fall >= 4), 1);
            last_fall = -1;
        end else if (FIFO_RD_INC) check("rd_inc_alone", 32'(FIFO_RD_INC), 32'(TX_DATA_VALID));
        if (FIFO_RD_INC && wp != rp) begin
            rp++;
            n_pop++;
        end
        if (!RST) begin
            bwait = 0; bhold = 0; mbusy = 1'b0; exp_frames = 0; last_fall = -1;
        end else begin
            if (bwait > 0) begin
                bwait--;
                if (bwait == 0) mbusy = 1'b1;
            end else if (mbusy) begin
                bhold--;
                if (bhold == 0) begin
                    mbusy = 1'b0;
                    exp_frames++;
                    last_fall = cyc;
                end
            end
            if (TX_DATA_VALID && ack_en) begin
                bwait = 1;
                bhold = blen_fix > 0 ? blen_fix : int'($urandom_range(1, 8));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_valid", 32'(TX_DATA_VALID), 0);
        check("rst_inc", 32'(FIFO_RD_INC), 0);
        check("rst_cnt", 32'(FRAME_CNT), 0);
        check("rst_err", 32'(TIMEOUT_ERR), 0);
        check("rst_sched", 32'(SCHED_BUSY), 0);
        RST = 1'b1;
        // single byte, fixed 10-cycle frame
        blen_fix = 10;
        push(8'hA5);
        EN = 1'b1;
        wait_quiet(200);
        check("single_cnt", 32'(FRAME_CNT), 32'(exp_frames % 16));
        check("single_pops", 32'(n_pop), 1);
        // burst with random frame lengths
        blen_fix = 0;
        p0 = n_pop;
        push(8'h11); push(8'h22); push(8'h33);
        wait_quiet(300);
        check("burst_cnt", 32'(FRAME_CNT), 32'(exp_frames % 16));
        check("burst_pops", 32'(n_pop - p0), 3);
        // transmitter never acknowledges
        ack_en = 1'b0;
        push(8'h5A);
        wait_valid(20);
        repeat (4) @(negedge CLK);
        check("err_early", 32'(TIMEOUT_ERR), 0);
        @(negedge CLK);
        check("err_set", 32'(TIMEOUT_ERR), 1);
        check("err_cnt", 32'(FRAME_CNT), 32'(exp_frames % 16));
        wait_quiet(50);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        check("err_clr", 32'(TIMEOUT_ERR), 0);
        ack_en = 1'b1;
        p0 = n_pop;
        push(8'($urandom));
        wait_quiet(200);
        check("after_err_pops", 32'(n_pop - p0), 1);
        check("after_err_cnt", 32'(FRAME_CNT), 32'(exp_frames % 16));
        // EN gating
        EN = 1'b0;
        p0 = n_pop;
        push(8'($urandom)); push(8'($urandom));
        repeat (50) @(negedge CLK);
        check("en_off_pops", 32'(n_pop - p0), 0);
        EN = 1'b1;
        wait_busy(20);
        EN = 1'b0;
        wait_quiet(200);
        repeat (10) @(negedge CLK);
        check("en_drop_pops", 32'(n_pop - p0), 1);
        check("en_drop_left", 32'(wp - rp), 1);
        check("en_drop_cnt", 32'(FRAME_CNT), 32'(exp_frames % 16));
        EN = 1'b1;
        wait_quiet(200);
        // reset in the middle of a frame
        push(8'h77);
        wait_busy(20);
        @(negedge CLK);
        check("pre_rst_cnt_nonzero", 32'(FRAME_CNT != 0), 1);
        RST = 1'b0;
        #1;
        check("mid_rst_sched", 32'(SCHED_BUSY), 0);
        check("mid_rst_cnt", 32'(FRAME_CNT), 0);
        check("mid_rst_data", 32'(TX_P_DATA), 0);
        check("mid_rst_valid", 32'(TX_DATA_VALID), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        // 17 random frames wrap the 4-bit counter
        for (int i = 0; i < 17; i++) push(8'($urandom));
        wait_quiet(2000);
        check("wrap_frames", 32'(exp_frames), 17);
        check("wrap_cnt", 32'(FRAME_CNT), 1);
        // external frame in progress blocks a start
        ext_busy = 1'b1;
        p0 = n_pop;
        push(8'($urandom));
        repeat (20) @(negedge CLK);
        check("ext_busy_block", 32'(n_pop - p0), 0);
        ext_busy = 1'b0;
        wait_valid(10);
        wait_quiet(200);
        check("ext_busy_pops", 32'(n_pop - p0), 1);
        check("final_cnt", 32'(FRAME_CNT), 32'(exp_frames % 16));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
